multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_ctrl_defs.sv | 103 ++++++++++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 130 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_defs.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// opcode constants and the select encodings also used by the ALU control decoder.
package mips_ctrl_defs;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_JR      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG_A  = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       mem_to_reg;
    logic       reg_dst;
  } sel_t;

  // Datapath selects depend only on the state, so they can be decoded ahead of time.
  function automatic sel_t decode_sel(input state_e s);
    sel_t r;
    r = '0;
    case (s)
      S_FETCH: begin
        r.mem_read  = 1'b1;
        r.alu_src_b = SRC_B_FOUR;
        r.alu_op    = ALU_OP_ADD;
        r.pc_source = PC_SRC_ALU;
      end
      S_DECODE: begin
        r.alu_src_b = SRC_B_IMM_SH2;
        r.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        r.alu_src_a = 1'b1;
        r.alu_src_b = SRC_B_IMM;
        r.alu_op    = ALU_OP_ADD;
      end
      S_MEMRD: begin
        r.mem_read = 1'b1;
        r.iord     = 1'b1;
      end
      S_MEMWB:  r.mem_to_reg = 1'b1;
      S_MEMWR:  r.iord       = 1'b1;
      S_EXEC: begin
        r.alu_src_a = 1'b1;
        r.alu_src_b = SRC_B_REG;
        r.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB:  r.reg_dst = 1'b1;
      S_BRANCH: begin
        r.alu_src_a = 1'b1;
        r.alu_src_b = SRC_B_REG;
        r.alu_op    = ALU_OP_SUB;
        r.pc_source = PC_SRC_ALUOUT;
      end
      S_JUMP:   r.pc_source = PC_SRC_JUMP;
      S_JR:     r.pc_source = PC_SRC_REG_A;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory state and flags a timeout
// once the count reaches MEM_TIMEOUT while memory is still not ready.
module mem_wait_timer
  import mips_ctrl_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [3:0] LIMIT = 4'(MEM_TIMEOUT);

  logic [3:0] count_q;
  logic [3:0] count_d;
  logic       stalled;

  // A wait state is only left on mem_ready or a timeout, so clearing on either
  // (or whenever we are not waiting) is the same as clearing on a state change.
  always_comb begin
    stalled = waiting && !mem_ready;
    timeout = stalled && (count_q == LIMIT);
    count_d = 4'd0;
    if (stalled && !timeout) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute states and drives
// the datapath selects (registered) and write strobes (gated by reset/timeout).
module multicycle_ctrl
  import mips_ctrl_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;
  sel_t   sel_q;
  sel_t   sel_d;
  logic   timeout;
  logic   illegal_d;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .waiting  (is_mem_wait(state_q)),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (timeout)        state_d = S_FETCH;
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (timeout)        state_d = S_FETCH;
        else if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        if (timeout || mem_ready) state_d = S_FETCH;
      end
      S_EXEC:    state_d = S_ALUWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
    sel_d = decode_sel(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      sel_q   <= decode_sel(S_FETCH);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Strobes react to this cycle's inputs, so they are decoded from state_q
  // and squashed while reset is high or the memory wait has timed out.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          pc_write = mem_ready && !timeout;
          ir_write = mem_ready && !timeout;
        end
        S_MEMWR:                       mem_write = !timeout;
        S_MEMWB, S_ALUWB, S_ADDI_WB:   reg_write = 1'b1;
        S_BRANCH:                      pc_write  = zero;
        S_JUMP, S_JR:                  pc_write  = 1'b1;
        default:                       pc_write  = 1'b0;
      endcase
      illegal_op = illegal_d;
      bus_err    = timeout;
    end
  end

  assign mem_read   = sel_q.mem_read;
  assign iord       = sel_q.iord;
  assign alu_src_a  = sel_q.alu_src_a;
  assign alu_src_b  = sel_q.alu_src_b;
  assign alu_op     = sel_q.alu_op;
  assign pc_source  = sel_q.pc_source;
  assign mem_to_reg = sel_q.mem_to_reg;
  assign reg_dst    = sel_q.reg_dst;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, memory
// stalls, the fetch timeout and reset, against hand-computed expectations.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic       mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, bus_err;
  logic [3:0] state;

  int compareCount = 0;
  int failCount    = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .iord      (iord),
    .mem_to_reg(mem_to_reg),
    .reg_dst   (reg_dst),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_source (pc_source),
    .illegal_op(illegal_op),
    .bus_err   (bus_err),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic mr);
    @(negedge clk);
    reset     = rst;
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = mr;
    #1;
  endtask

  // Strobe vector order: {pc_write, ir_write, reg_write, mem_write, illegal_op, bus_err}
  task automatic checkCycle(input string tag, input logic [3:0] expState, input logic [5:0] expStrobes);
    checkOutput({tag, " state"}, 32'(state), 32'(expState));
    checkOutput({tag, " strobes"},
                32'({pc_write, ir_write, reg_write, mem_write, illegal_op, bus_err}),
                32'(expStrobes));
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;

    applyStimulus(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b1);
    checkOutput("reset0 strobes",
                32'({pc_write, ir_write, reg_write, mem_write, illegal_op, bus_err}), 32'd0);
    applyStimulus(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b1);
    checkCycle("reset1", 4'd0, 6'b000000);
    checkOutput("reset1 mem_read", 32'(mem_read), 32'd1);

    // R-type add, zero-wait memory
    applyStimulus(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    checkCycle("add fetch", 4'd0, 6'b110000);
    checkOutput("add fetch alu_src_b", 32'(alu_src_b), 32'h1);
    checkOutput("add fetch iord", 32'(iord), 32'h0);
    applyStimulus(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    checkCycle("add decode", 4'd1, 6'b000000);
    checkOutput("add decode alu_src_b", 32'(alu_src_b), 32'h3);
    applyStimulus(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    checkCycle("add exec", 4'd6, 6'b000000);
    checkOutput("add exec alu_op", 32'(alu_op), 32'h2);
    checkOutput("add exec alu_src_a", 32'(alu_src_a), 32'h1);
    applyStimulus(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    checkCycle("add aluwb", 4'd7, 6'b001000);
    checkOutput("add aluwb reg_dst", 32'(reg_dst), 32'h1);

    // lw with three stalled cycles in MEMRD
    applyStimulus(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1);
    checkCycle("lw fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1);
    checkCycle("lw decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1);
    checkCycle("lw memadr", 4'd2, 6'b000000);
    checkOutput("lw memadr alu_src_b", 32'(alu_src_b), 32'h2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b0);
      checkCycle($sformatf("lw memrd stall%0d", i), 4'd3, 6'b000000);
    end
    checkOutput("lw memrd iord", 32'(iord), 32'h1);
    checkOutput("lw memrd mem_read", 32'(mem_read), 32'h1);
    applyStimulus(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1);
    checkCycle("lw memrd ready", 4'd3, 6'b000000);
    applyStimulus(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b0);
    checkCycle("lw memwb", 4'd4, 6'b001000);
    checkOutput("lw memwb mem_to_reg", 32'(mem_to_reg), 32'h1);

    // beq taken then not taken
    applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1);
    checkCycle("beq1 fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1);
    checkCycle("beq1 decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1);
    checkCycle("beq1 branch", 4'd8, 6'b100000);
    checkOutput("beq1 pc_source", 32'(pc_source), 32'h1);
    checkOutput("beq1 alu_op", 32'(alu_op), 32'h1);
    applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1);
    checkCycle("beq0 fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1);
    checkCycle("beq0 decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1);
    checkCycle("beq0 branch", 4'd8, 6'b000000);

    // j and jr
    applyStimulus(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1);
    checkCycle("j fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1);
    checkCycle("j decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1);
    checkCycle("j jump", 4'd9, 6'b100000);
    checkOutput("j pc_source", 32'(pc_source), 32'h2);
    applyStimulus(1'b0, 6'b000000, 6'b001000, 1'b0, 1'b1);
    checkCycle("jr fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b000000, 6'b001000, 1'b0, 1'b1);
    checkCycle("jr decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b000000, 6'b001000, 1'b0, 1'b1);
    checkCycle("jr jr", 4'd12, 6'b100000);
    checkOutput("jr pc_source", 32'(pc_source), 32'h3);

    // addi
    applyStimulus(1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1);
    checkCycle("addi fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1);
    checkCycle("addi decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1);
    checkCycle("addi ex", 4'd10, 6'b000000);
    checkOutput("addi ex alu_src_b", 32'(alu_src_b), 32'h2);
    applyStimulus(1'b0, 6'b001000, 6'b000000, 1'b0, 1'b1);
    checkCycle("addi wb", 4'd11, 6'b001000);
    checkOutput("addi wb reg_dst", 32'(reg_dst), 32'h0);

    // sw, zero-wait
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1);
    checkCycle("sw fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1);
    checkCycle("sw decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1);
    checkCycle("sw memadr", 4'd2, 6'b000000);
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1);
    checkCycle("sw memwr", 4'd5, 6'b000100);
    checkOutput("sw memwr iord", 32'(iord), 32'h1);

    // illegal opcode
    applyStimulus(1'b0, 6'b111111, 6'b000000, 1'b0, 1'b1);
    checkCycle("ill fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b111111, 6'b000000, 1'b0, 1'b1);
    checkCycle("ill decode", 4'd1, 6'b000010);

    // Fetch timeout twice in a row: bus_err on every 16th stalled cycle
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 16; c++) begin
        applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0);
        checkCycle($sformatf("timeout r%0d c%0d", r, c), 4'd0,
                   (c == 16) ? 6'b000001 : 6'b000000);
      end
    end

    // Reset in the middle of a stalled sw
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1);
    checkCycle("rsw fetch", 4'd0, 6'b110000);
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1);
    checkCycle("rsw decode", 4'd1, 6'b000000);
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1);
    checkCycle("rsw memadr", 4'd2, 6'b000000);
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0);
    checkCycle("rsw memwr stall", 4'd5, 6'b000100);
    applyStimulus(1'b1, 6'b101011, 6'b000000, 1'b0, 1'b0);
    checkCycle("rsw reset cycle", 4'd5, 6'b000000);
    applyStimulus(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0);
    checkCycle("rsw after reset", 4'd0, 6'b000000);
    checkOutput("rsw after reset mem_read", 32'(mem_read), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
